// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter: FSM states and the cache line type.
package pmem_arbiter_pkg;

  typedef logic [255:0] cache_line_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    TURN    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/pmem_arb_grant.sv
// Winner select between I and D requests plus the anti-starvation counter.
module pmem_arb_grant
  import pmem_arbiter_pkg::*;
#(
  parameter bit          D_PRIORITY   = 1'b1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  output logic win_i,
  output logic win_d
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             fav_req, oth_req, starved, win_fav, win_oth;

  always_comb begin
    fav_req      = D_PRIORITY ? d_req : i_req;
    oth_req      = D_PRIORITY ? i_req : d_req;
    starved      = (starve_cnt_q == LIMIT);
    win_oth      = arb_en && oth_req && (starved || !fav_req);
    win_fav      = arb_en && fav_req && !win_oth;
    starve_cnt_d = starve_cnt_q;
    // Count only favoured wins that actually made the other side wait.
    if (win_oth) begin
      starve_cnt_d = '0;
    end else if (win_fav) begin
      if (!oth_req) begin
        starve_cnt_d = '0;
      end else if (!starved) begin
        starve_cnt_d = starve_cnt_q + CNT_W'(1);
      end
    end
    win_d = D_PRIORITY ? win_fav : win_oth;
    win_i = D_PRIORITY ? win_oth : win_fav;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Shares one line-wide memory port between I-cache fills and D-cache fills/write-backs.
//
// state   | meaning
// IDLE    | arbitrate; latch winner's address/op/wdata
// SERVE_I | I-cache fill in flight, mem_read high
// SERVE_D | D-cache fill or write-back in flight
// TURN    | one dead cycle so the served cache drops its request
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter int unsigned S_LINE       = 256,
  parameter int unsigned S_ADDR       = 32,
  parameter bit          D_PRIORITY   = 1'b1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [S_ADDR-1:0] i_pmem_address,
  output logic [S_LINE-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [S_ADDR-1:0] d_pmem_address,
  input  logic [S_LINE-1:0] d_pmem_wdata,
  output logic [S_LINE-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [S_ADDR-1:0] mem_address,
  output logic [S_LINE-1:0] mem_wdata,
  input  logic [S_LINE-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state_q, state_d;
  logic [S_ADDR-1:0] addr_q, addr_d;
  logic [S_LINE-1:0] wdata_q, wdata_d;
  logic              op_write_q, op_write_d;
  logic              arb_en, win_i, win_d;

  pmem_arb_grant #(
    .D_PRIORITY  (D_PRIORITY),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk   (clk),
    .rst   (rst),
    .arb_en(arb_en),
    .i_req (i_pmem_read),
    .d_req (d_pmem_read | d_pmem_write),
    .win_i (win_i),
    .win_d (win_d)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    op_write_d = op_write_q;
    arb_en     = 1'b0;
    case (state_q)
      IDLE: begin
        arb_en = 1'b1;
        // A simultaneous read+write from D is resolved as a write-back.
        if (win_d) begin
          state_d    = SERVE_D;
          addr_d     = d_pmem_address;
          wdata_d    = d_pmem_wdata;
          op_write_d = d_pmem_write;
        end else if (win_i) begin
          state_d    = SERVE_I;
          addr_d     = i_pmem_address;
          op_write_d = 1'b0;
        end
      end
      SERVE_I: if (mem_resp) state_d = TURN;
      SERVE_D: if (mem_resp) state_d = TURN;
      TURN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read     = (state_q == SERVE_I) || ((state_q == SERVE_D) && !op_write_q);
    mem_write    = (state_q == SERVE_D) && op_write_q;
    mem_address  = addr_q;
    mem_wdata    = wdata_q;
    i_pmem_resp  = (state_q == SERVE_I) && mem_resp;
    d_pmem_resp  = (state_q == SERVE_D) && mem_resp;
    i_pmem_rdata = i_pmem_resp ? mem_rdata : '0;
    d_pmem_rdata = d_pmem_resp ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      op_write_q <= op_write_d;
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: fills, priority, starvation, latching, reset and spurious responses.
module tb_pmem_arbiter;
  import pmem_arbiter_pkg::*;

  localparam int S_LINE = 256;
  localparam int S_ADDR = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_pmem_read = 1'b0;
  logic [S_ADDR-1:0] i_pmem_address = '0;
  logic [S_LINE-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read = 1'b0;
  logic              d_pmem_write = 1'b0;
  logic [S_ADDR-1:0] d_pmem_address = '0;
  logic [S_LINE-1:0] d_pmem_wdata = '0;
  logic [S_LINE-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              mem_read;
  logic              mem_write;
  logic [S_ADDR-1:0] mem_address;
  logic [S_LINE-1:0] mem_wdata;
  logic [S_LINE-1:0] mem_rdata = '0;
  logic              mem_resp = 1'b0;

  pmem_arbiter #(
    .S_LINE(S_LINE), .S_ADDR(S_ADDR), .D_PRIORITY(1'b1), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  int n_tests  = 0;
  int n_fail   = 0;
  int i_pulses = 0;
  int d_pulses = 0;

  always @(posedge clk) begin
    if (i_pmem_resp) i_pulses++;
    if (d_pmem_resp) d_pulses++;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // The two downstream strobes must never be high together.
  always @(negedge clk) begin
    if (!rst) check("one_strobe", {255'b0, mem_read & mem_write}, 256'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one step after the edge that moved the FSM into SERVE; leaves in TURN.
  task automatic serve(input string tag, input bit side_d, input logic [31:0] exp_addr,
                       input bit exp_wr, input logic [255:0] exp_wdata, input int lat,
                       input logic [255:0] line);
    check({tag, "_rd"}, {255'b0, mem_read}, {255'b0, !exp_wr});
    check({tag, "_wr"}, {255'b0, mem_write}, {255'b0, exp_wr});
    if (exp_wr) check({tag, "_wdata"}, mem_wdata, exp_wdata);
    for (int c = 1; c < lat; c++) begin
      check({tag, "_addr_wait"}, {224'b0, mem_address}, {224'b0, exp_addr});
      check({tag, "_early_resp"}, {254'b0, i_pmem_resp, d_pmem_resp}, 256'd0);
      tick();
    end
    mem_rdata = line;
    mem_resp  = 1'b1;
    #1;
    check({tag, "_addr"}, {224'b0, mem_address}, {224'b0, exp_addr});
    check({tag, "_i_resp"}, {255'b0, i_pmem_resp}, {255'b0, !side_d});
    check({tag, "_d_resp"}, {255'b0, d_pmem_resp}, {255'b0, side_d});
    check({tag, "_i_rdata"}, i_pmem_rdata, side_d ? 256'd0 : line);
    check({tag, "_d_rdata"}, d_pmem_rdata, side_d ? line : 256'd0);
    tick();
    mem_resp = 1'b0;
    if (side_d) begin
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
    end else begin
      i_pmem_read = 1'b0;
    end
    #1;
    check({tag, "_turn_strobes"}, {254'b0, mem_read, mem_write}, 256'd0);
  endtask

  localparam logic [255:0] LINE_A5 = {32{8'hA5}};
  localparam logic [255:0] W_1234  = {16{16'h1234}};
  localparam logic [255:0] W_BEEF  = {16{16'hBEEF}};
  localparam logic [255:0] W_0F0F  = {16{16'h0F0F}};
  localparam logic [255:0] W_5A5A  = {16{16'h5A5A}};

  bit  order_d [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  int  cnt_exp [7] = '{1, 2, 3, 4, 0, 0, 0};

  initial begin
    cache_line_t line;
    int k;
    int pi, pd;

    // Reset state
    tick();
    tick();
    check("rst_state", {254'b0, dut.state_q}, {254'b0, IDLE});
    check("rst_strobes", {254'b0, mem_read, mem_write}, 256'd0);
    check("rst_resps", {254'b0, i_pmem_resp, d_pmem_resp}, 256'd0);
    check("rst_addr", {224'b0, mem_address}, 256'd0);
    check("rst_wdata", mem_wdata, 256'd0);
    check("rst_rdata", i_pmem_rdata | d_pmem_rdata, 256'd0);
    check("rst_cnt", 256'(dut.u_grant.starve_cnt_q), 256'd0);
    rst = 1'b0;
    tick();

    // I fill alone
    i_pulses = 0; d_pulses = 0;
    i_pmem_read = 1'b1; i_pmem_address = 32'h40;
    #1;
    check("fill_lat0", {255'b0, mem_read}, 256'd0);
    tick();
    check("fill_addr", {224'b0, mem_address}, 256'h40);
    serve("fill", 1'b0, 32'h40, 1'b0, 256'd0, 5, LINE_A5);
    tick();
    check("fill_i_pulses", 256'(i_pulses), 256'd1);
    check("fill_d_pulses", 256'(d_pulses), 256'd0);

    // Simultaneous I read / D write, D wins
    i_pmem_read = 1'b1; i_pmem_address = 32'h100;
    d_pmem_write = 1'b1; d_pmem_address = 32'h200; d_pmem_wdata = W_1234;
    tick();
    serve("sim_d", 1'b1, 32'h200, 1'b1, W_1234, 2, 256'd0);
    tick();
    check("sim_idle_gap", {254'b0, mem_read, mem_write}, 256'd0);
    tick();
    serve("sim_i", 1'b0, 32'h100, 1'b0, 256'd0, 3, W_5A5A);
    tick();

    // Starvation: I held while D streams six reads
    i_pulses = 0;
    i_pmem_read = 1'b1; i_pmem_address = 32'h2000;
    d_pmem_read = 1'b1; d_pmem_address = 32'h1000;
    k = 0;
    for (int j = 0; j < 7; j++) begin
      tick();
      check($sformatf("starve_cnt%0d", j), 256'(dut.u_grant.starve_cnt_q), 256'(cnt_exp[j]));
      line = {8{j[31:0]}};
      serve($sformatf("starve%0d", j), order_d[j],
            order_d[j] ? (32'h1000 + 32'(k) * 32'h40) : 32'h2000, 1'b0, 256'd0, 1, line);
      if (order_d[j]) begin
        k++;
        d_pmem_address = 32'h1000 + 32'(k) * 32'h40;
        d_pmem_read = (k < 6);
      end
      tick();
    end
    check("starve_i_pulses", 256'(i_pulses), 256'd1);

    // Address and wdata latched at grant
    d_pmem_write = 1'b1; d_pmem_address = 32'h300; d_pmem_wdata = W_BEEF;
    tick();
    d_pmem_address = 32'h380; d_pmem_wdata = W_0F0F;
    serve("latch", 1'b1, 32'h300, 1'b1, W_BEEF, 4, 256'd0);
    tick();

    // Reset two cycles into SERVE_D
    i_pmem_read = 1'b1; i_pmem_address = 32'h600;
    d_pmem_read = 1'b1; d_pmem_address = 32'h400;
    tick();
    check("rstmid_serve", {254'b0, mem_read, mem_write}, 256'd2);
    check("rstmid_cnt_pre", 256'(dut.u_grant.starve_cnt_q), 256'd1);
    tick();
    rst = 1'b1; i_pmem_read = 1'b0; d_pmem_read = 1'b0;
    tick();
    check("rstmid_strobes", {254'b0, mem_read, mem_write}, 256'd0);
    check("rstmid_state", {254'b0, dut.state_q}, {254'b0, IDLE});
    check("rstmid_cnt", 256'(dut.u_grant.starve_cnt_q), 256'd0);
    rst = 1'b0;
    pi = i_pulses; pd = d_pulses;
    mem_rdata = LINE_A5; mem_resp = 1'b1;
    #1;
    check("late_resp", {254'b0, i_pmem_resp, d_pmem_resp}, 256'd0);
    tick();
    mem_resp = 1'b0;
    check("late_pulses", 256'(i_pulses + d_pulses), 256'(pi + pd));

    // Spurious mem_resp in IDLE with dual D request
    pd = d_pulses;
    mem_resp = 1'b1; mem_rdata = W_5A5A;
    d_pmem_read = 1'b1; d_pmem_write = 1'b1;
    d_pmem_address = 32'h500; d_pmem_wdata = W_0F0F;
    #1;
    check("spur_idle_resp", {254'b0, i_pmem_resp, d_pmem_resp}, 256'd0);
    tick();
    mem_resp = 1'b0;
    #1;
    serve("dual", 1'b1, 32'h500, 1'b1, W_0F0F, 2, LINE_A5);
    mem_resp = 1'b1;
    #1;
    check("spur_turn_resp", {254'b0, i_pmem_resp, d_pmem_resp}, 256'd0);
    tick();
    mem_resp = 1'b0;
    tick();
    check("dual_pulses", 256'(d_pulses), 256'(pd + 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single 256-bit physical-memory port between the instruction cache (read-only line fills) and the data cache (line fills and dirty write-backs).
- Sits between both cache instances' pmem_* interfaces and the main-memory model/bus adapter.
- Grants one whole line transaction at a time and registers the winning request.
- Routes the response back to the winner only. Includes an anti-starvation counter so I-fetch cannot be blocked indefinitely by D traffic.

Parameters:
- S_LINE, 256, line width in bits (data ports).
- S_ADDR, 32, address width.
- D_PRIORITY, 1, 1 = data cache wins simultaneous requests; 0 = instruction cache wins.
- STARVE_LIMIT, 4, consecutive grants to the favoured side while the other side waits before the other side is forced.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- i_pmem_read  in  1  I-cache line fill request; held until i_pmem_resp.
- i_pmem_address  in  S_ADDR  I-cache line address.
- i_pmem_rdata  out  S_LINE  fill data to I-cache.
- i_pmem_resp  out  1  one-cycle completion pulse to I-cache.
- d_pmem_read  in  1  D-cache fill request; held until d_pmem_resp.
- d_pmem_write  in  1  D-cache write-back request; held until d_pmem_resp.
- d_pmem_address  in  S_ADDR  D-cache line address.
- d_pmem_wdata  in  S_LINE  write-back line.
- d_pmem_rdata  out  S_LINE  fill data to D-cache.
- d_pmem_resp  out  1  one-cycle completion pulse to D-cache.
- mem_read  out  1  downstream read strobe.
- mem_write  out  1  downstream write strobe.
- mem_address  out  S_ADDR  downstream address (registered).
- mem_wdata  out  S_LINE  downstream write data (registered).
- mem_rdata  in  S_LINE  downstream read data, valid with mem_resp.
- mem_resp  in  1  downstream completion.

Behaviour:
- Reset values:
  - State IDLE; mem_read, mem_write, i_pmem_resp, d_pmem_resp = 0.
  - mem_address and mem_wdata = 0; starve counter = 0.
  - i_pmem_rdata and d_pmem_rdata = 0.
- FSM states: IDLE, SERVE_I, SERVE_D, TURN.
- IDLE:
  - Sample requests. Winner per D_PRIORITY unless the starve counter equals STARVE_LIMIT, in which case the non-favoured side wins.
  - On a grant, register the address (and wdata/op for D) and go to SERVE_x.
  - mem_read/mem_write assert from the cycle after the grant, i.e. 1-cycle arbitration latency.
- SERVE_I: mem_read=1. On mem_resp:
  - i_pmem_resp=1 in that same cycle (combinational from mem_resp).
  - i_pmem_rdata = mem_rdata.
  - Go to TURN.
- SERVE_D: mem_read or mem_write=1 per the latched op. On mem_resp, d_pmem_resp=1 with d_pmem_rdata = mem_rdata; go to TURN.
- TURN: one idle cycle with no strobes, so the served cache drops its request before re-arbitration; then IDLE.
- Data routing:
  - The non-granted side's resp is always 0.
  - Its rdata is don't-care but driven as 0.
- Starve counter:
  - Increments on each grant to the favoured side while the other side's request is asserted.
  - Clears on any grant to the non-favoured side, or on a favoured grant with the other side idle.
  - Saturates at STARVE_LIMIT.
- d_pmem_read and d_pmem_write both high: illegal; write is taken and read is ignored (assertion in bench).
- mem_resp while in IDLE or TURN: ignored, no resp generated.
- Request dropped before grant: simply not granted. Requests must not drop after grant; address and wdata are latched, so changes after grant have no effect.
- rst mid-transaction: state forced to IDLE at the next edge, strobes low, transaction abandoned, counter cleared.
- No back-to-back transactions: minimum 3 cycles per transaction (grant, ≥1 serve, turn).

Decomposition:
- Shared package (rv32i_types or a new cache_types):
  - enum arb_state_t {IDLE, SERVE_I, SERVE_D, TURN}.
  - Typedef cache_line_t = logic[255:0].
- One sub-module is natural: pmem_arb_grant, the combinational winner select plus starve counter register, kept separate so fairness can be tested alone.
- Top pmem_arbiter contains the FSM, request latches and response routing.
- The top-level cpu instantiates pmem_arbiter between the two cache instances and memory.

Test Plan:
- I fill alone, addr 0x0000_0040, memory responds after 5 cycles with line 0xA5…A5:
  - mem_read rises 1 cycle after request; mem_address = 0x40.
  - i_pmem_resp pulses once with rdata 0xA5…A5; d_pmem_resp stays 0.
- Simultaneous I read 0x100 and D write 0x200 (wdata 0x1234…) with D_PRIORITY=1:
  - D served first: mem_write=1, address 0x200, wdata latched.
  - After TURN, I served at 0x100.
- Starvation: I read held while D issues 6 back-to-back reads, STARVE_LIMIT=4:
  - Grant order D,D,D,D,I, then D continues; I resp arrives before the 5th D grant.
- Requester changes d_pmem_address from 0x300 to 0x380 after grant: mem_address stays 0x300 through resp.
- rst asserted 2 cycles into SERVE_D: next cycle mem_read=mem_write=0 and state IDLE; a late mem_resp then produces no resp pulse.
- Spurious mem_resp in IDLE, with d_pmem_read and d_pmem_write both asserted:
  - No resp pulses from the spurious mem_resp.
  - The dual request is treated as a write: mem_write=1, mem_read=0.
